pkt_sink: RTL and testbench
===========================

# pkt_sink

Store-and-forward packet receiver that terminates the framed valid/ready byte stream produced by the stimulus side of the dummy-model environment. Each packet is buffered in an internal FIFO and its trailing XOR checksum is verified. Good packets are committed and forwarded downstream. Bad, overflowing or mis-framed packets are rewound and discarded. Every terminated packet yields exactly one status response.

## Interface
Parameters:
- DW, 8, data width of every beat.
- DEPTH, 16, FIFO entries (power of 2, ≥2); AW = $clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DW  beat data.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet; this beat is the checksum word.
- out_valid  out  1  committed payload word available.
- out_ready  in  1  downstream accepts word.
- out_data  out  DW  payload word.
- out_last  out  1  final payload word of a packet.
- rsp_valid  out  1  status response valid, held until rsp_ready.
- rsp_ready  in  1  response accepted.
- rsp_code  out  2  00 ok, 01 bad checksum, 10 overflow, 11 framing error.
- rsp_len  out  AW+1  payload words received (checksum word excluded).
- good_cnt  out  16  committed packets, wraps at 2^16.
- drop_cnt  out  16  discarded packets (codes 01/10/11), wraps at 2^16.

## Operation
- FIFO pointers are AW+1 bits each:
  - rd_ptr: read pointer.
  - wr_ptr: speculative write pointer.
  - wr_cmt: committed write pointer.
- Each FIFO entry stores {last, data}.
- Packet payload = all beats before the eop beat. The eop beat carries the expected checksum = XOR of all payload beats.
- FSM states:
  - IDLE:
    - sop beat without eop → RECV; its data is the first payload word; start value = 0.
    - sop&eop beat → zero-length packet → RESP; ok iff data==0, else 01.
    - Non-sop beats are consumed and discarded; no response, no counter change.
  - RECV:
    - Payload beat: written at wr_ptr; wr_ptr++; running XOR and len updated.
    - eop beat with checksum match:
      - wr_cmt ← wr_ptr.
      - last bit of entry wr_ptr−1 is set, if len>0.
      - code 00 → RESP.
    - eop beat with checksum mismatch: wr_ptr ← wr_cmt, code 01 → RESP.
    - sop beat (with or without eop): wr_ptr ← wr_cmt, code 11 → RESP. That beat is consumed and discarded.
    - Payload beat while FIFO full (wr_ptr−rd_ptr == DEPTH, read side included): wr_ptr ← wr_cmt, code 10 → DROP. The beat is discarded.
  - DROP:
    - Consume beats until eop, then → RESP. rsp_len = payload words received, including discarded ones, saturating at 2^(AW+1)−1.
    - sop beat in DROP: → RESP with code 10 retained.
  - RESP:
    - rsp_valid=1, in_ready=0.
    - On rsp_ready: → IDLE; good_cnt++ if code 00, else drop_cnt++.
- in_ready = 1 in IDLE, RECV and DROP; 0 in RESP.
- out_valid = (rd_ptr != wr_cmt). Read pops on out_valid && out_ready.
- Output path is independent of the FSM: reads proceed in every state, including RESP.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_last=0.
  - rsp_valid=0, rsp_code=00, rsp_len=0.
  - good_cnt=0, drop_cnt=0.
  - All pointers 0, FSM in IDLE.
- Reset asserted mid-packet or mid-response discards everything immediately (asynchronous); no response is issued.
- eop accepted at edge N:
  - rsp_valid=1 from cycle N+1.
  - Committed words visible on out_valid from cycle N+1.
- One beat per cycle max on input and on output. Simultaneous read and write in the same cycle are both honoured.
- Full check uses the pre-edge rd_ptr: a pop in the same cycle as a full-condition write does not rescue that write.
- out_data and out_last are combinational from the FIFO head entry, registered storage.
- rsp_* outputs are stable while rsp_valid && !rsp_ready.
- Back-to-back packets: minimum 1 idle input cycle per packet (the RESP cycle) when rsp_ready is tied high.

## Test plan
- Good packet: sop 0x11, 0x22, 0x33, eop 0x00 (0x11^0x22^0x33=0x00) → rsp 00/len 3 at N+1; out 0x11, 0x22, 0x33 with out_last on 0x33; good_cnt=1.
- Bad checksum: sop 0xA5, 0x5A, eop 0x00 → rsp 01/len 2; no out_valid; FIFO pointers back to pre-packet values; drop_cnt=1.
- Overflow with DEPTH=16 and out_ready=0: 17 payload beats then eop → rsp 10; no words forwarded. A following good 2-word packet passes intact.
- Framing: sop 0x01, 0x02, then sop 0x03 → rsp 11/len 2. Then sop&eop 0x00 → rsp 00/len 0, no output word.
- Response backpressure: rsp_ready=0 for 5 cycles after a good packet → in_ready=0 and rsp fields stable for all 5 cycles; the output side drains during the stall.
- Async reset asserted mid-RECV after 3 beats → all outputs at reset values within the same cycle; no response issued; a subsequent good packet behaves normally.

Source files
------------

// File: rtl/pkt_sink_if.sv
// rtl/pkt_sink_if.sv - framed input stream, payload output stream and status response bundle
interface pkt_sink_if #(
    parameter int DW = 8,
    parameter int LW = 5
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sop;
    logic          in_eop;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_code;
    logic [LW-1:0] rsp_len;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready, rsp_ready,
        output in_ready, out_valid, out_data, out_last, rsp_valid, rsp_code, rsp_len
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready, rsp_ready,
        input  in_ready, out_valid, out_data, out_last, rsp_valid, rsp_code, rsp_len
    );
endinterface

// File: rtl/pkt_sink.sv
// rtl/pkt_sink.sv - store-and-forward packet sink with XOR checksum check and rewindable FIFO
module pkt_sink #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    pkt_sink_if.slave   bus,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, DROP, RESP} state_t;

    localparam logic [1:0] CODE_OK  = 2'b00;
    localparam logic [1:0] CODE_BAD = 2'b01;
    localparam logic [1:0] CODE_OVF = 2'b10;
    localparam logic [1:0] CODE_FRM = 2'b11;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    state_t        state_q, state_d;
    logic [AW:0]   rd_ptr_q, wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d;
    logic [DW-1:0] xor_q, xor_d;
    logic [AW:0]   len_q, len_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   good_q, good_d, drop_q, drop_d;
    logic [DW-1:0] mem_data_q [DEPTH];
    logic          mem_last_q [DEPTH];

    logic          in_beat, full, we, set_last, pop;
    logic [AW:0]   last_ptr;

    assign bus.in_ready  = (state_q != RESP);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_code  = code_q;
    assign bus.rsp_len   = len_q;
    assign bus.out_valid = (rd_ptr_q != wr_cmt_q);
    assign bus.out_data  = mem_data_q[rd_ptr_q[AW-1:0]];
    assign bus.out_last  = mem_last_q[rd_ptr_q[AW-1:0]];
    assign good_cnt      = good_q;
    assign drop_cnt      = drop_q;

    assign in_beat  = bus.in_valid && bus.in_ready;
    // Full uses the pre-edge read pointer, so a same-cycle pop cannot rescue a write.
    assign full     = ((wr_ptr_q - rd_ptr_q) == FULL_CNT);
    assign pop      = bus.out_valid && bus.out_ready;
    assign last_ptr = wr_ptr_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_cmt_d = wr_cmt_q;
        xor_d    = xor_q;
        len_d    = len_q;
        code_d   = code_q;
        good_d   = good_q;
        drop_d   = drop_q;
        we       = 1'b0;
        set_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_beat && bus.in_sop) begin
                    if (bus.in_eop) begin
                        code_d  = (bus.in_data == '0) ? CODE_OK : CODE_BAD;
                        len_d   = '0;
                        state_d = RESP;
                    end else if (full) begin
                        code_d  = CODE_OVF;
                        len_d   = 1;
                        state_d = DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        xor_d    = bus.in_data;
                        len_d    = 1;
                        state_d  = RECV;
                    end
                end
            end
            RECV: begin
                if (in_beat) begin
                    if (bus.in_sop) begin
                        wr_ptr_d = wr_cmt_q;
                        code_d   = CODE_FRM;
                        state_d  = RESP;
                    end else if (bus.in_eop) begin
                        if (xor_q == bus.in_data) begin
                            wr_cmt_d = wr_ptr_q;
                            set_last = (len_q != '0);
                            code_d   = CODE_OK;
                        end else begin
                            wr_ptr_d = wr_cmt_q;
                            code_d   = CODE_BAD;
                        end
                        state_d = RESP;
                    end else if (full) begin
                        wr_ptr_d = wr_cmt_q;
                        code_d   = CODE_OVF;
                        len_d    = len_q + 1'b1;
                        state_d  = DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        xor_d    = xor_q ^ bus.in_data;
                        len_d    = len_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (in_beat) begin
                    if (bus.in_sop || bus.in_eop) begin
                        state_d = RESP;
                    end else if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    if (code_q == CODE_OK) good_d = good_q + 1'b1;
                    else                   drop_d = drop_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            wr_cmt_q <= '0;
            xor_q    <= '0;
            len_q    <= '0;
            code_q   <= CODE_OK;
            good_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, pop};
            wr_ptr_q <= wr_ptr_d;
            wr_cmt_q <= wr_cmt_d;
            xor_q    <= xor_d;
            len_q    <= len_d;
            code_q   <= code_d;
            good_q   <= good_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is cleared on reset so the head entry reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            if (we) begin
                mem_data_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
                mem_last_q[wr_ptr_q[AW-1:0]] <= 1'b0;
            end
            if (set_last) begin
                mem_last_q[last_ptr[AW-1:0]] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pkt_sink.sv
// tb/tb_pkt_sink.sv - scoreboard bench for pkt_sink with directed packets
module tb_pkt_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] good_cnt, drop_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_out [$];
    logic [6:0]  exp_rsp [$];
    logic [7:0]  pl [32];

    pkt_sink_if #(.DW(8), .LW(5)) bus ();

    pkt_sink #(.DW(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .good_cnt (good_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) chk("out_unexpected", {bus.out_last, bus.out_data}, 32'hFFFF);
                else chk("out_word", {bus.out_last, bus.out_data}, exp_out.pop_front());
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", {bus.rsp_code, bus.rsp_len}, 32'hFFFF);
                else chk("rsp_code_len", {bus.rsp_code, bus.rsp_len}, exp_rsp.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_data  = '0;
    endtask

    // n payload words from pl[], then eop carrying ck
    task automatic send_pkt(input int n, input logic [7:0] ck, input logic [1:0] code, input bit fwd);
        exp_rsp.push_back({code, 5'(n)});
        if (fwd) begin
            for (int i = 0; i < n; i++) exp_out.push_back({(i == n - 1), pl[i]});
        end
        if (n == 0) begin
            send_beat(ck, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) send_beat(pl[i], (i == 0), 1'b0);
            send_beat(ck, 1'b0, 1'b1);
        end
        idle_in();
        @(negedge clk);
        chk("rsp_valid_n1", bus.rsp_valid, 1);
        if (fwd && n > 0) chk("out_valid_n1", bus.out_valid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_out.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("drain_timeout", exp_out.size() + exp_rsp.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_code"}, bus.rsp_code, 0);
        chk({tag, "_rsp_len"}, bus.rsp_len, 0);
        chk({tag, "_good_cnt"}, good_cnt, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        idle_in();
        bus.out_ready = 1'b1;
        bus.rsp_ready = 1'b1;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(3, 8'h00, 2'b00, 1'b1);
        wait_drain();
        chk("good1_good_cnt", good_cnt, 1);
        chk("good1_drop_cnt", drop_cnt, 0);

        pl[0] = 8'hA5; pl[1] = 8'h5A;
        send_pkt(2, 8'h00, 2'b01, 1'b0);
        wait_drain();
        chk("bad_out_valid", bus.out_valid, 0);
        chk("bad_drop_cnt", drop_cnt, 1);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) pl[i] = 8'(i + 1);
        send_pkt(17, 8'h00, 2'b10, 1'b0);
        wait_drain();
        chk("ovf_out_valid", bus.out_valid, 0);
        chk("ovf_drop_cnt", drop_cnt, 2);
        bus.out_ready = 1'b1;
        pl[0] = 8'h0F; pl[1] = 8'hF0;
        send_pkt(2, 8'hFF, 2'b00, 1'b1);
        wait_drain();
        chk("ovf_next_good_cnt", good_cnt, 2);

        exp_rsp.push_back({2'b11, 5'd2});
        send_beat(8'h01, 1'b1, 1'b0);
        send_beat(8'h02, 1'b0, 1'b0);
        send_beat(8'h03, 1'b1, 1'b0);
        idle_in();
        wait_drain();
        send_pkt(0, 8'h00, 2'b00, 1'b1);
        wait_drain();
        chk("frm_out_valid", bus.out_valid, 0);
        chk("frm_good_cnt", good_cnt, 3);
        chk("frm_drop_cnt", drop_cnt, 3);

        bus.rsp_ready = 1'b0;
        pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30; pl[3] = 8'h40;
        send_pkt(4, 8'h40, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_fields", {bus.rsp_code, bus.rsp_len}, {2'b00, 5'd4});
        end
        chk("bp_drained", exp_out.size(), 0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain();
        chk("bp_good_cnt", good_cnt, 4);

        bus.out_ready = 1'b0;
        send_beat(8'h55, 1'b1, 1'b0);
        send_beat(8'h66, 1'b0, 1'b0);
        send_beat(8'h77, 1'b0, 1'b0);
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(negedge clk);
        chk("arst_no_rsp", bus.rsp_valid, 0);
        chk("arst_no_out", bus.out_valid, 0);
        @(posedge clk);
        #1;
        pl[0] = 8'hAB; pl[1] = 8'hCD;
        send_pkt(2, 8'h66, 2'b00, 1'b1);
        wait_drain();
        chk("arst_good_cnt", good_cnt, 1);
        chk("arst_drop_cnt", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
